polar_simd_unit: RTL

- Pipelined, parametrised successor of the ALU's single-lane polar-decoding ops (F, G, R).
- Operates on LANES packed QTF_SIZE-bit signed LLRs per operand word.
- Symmetric saturation, valid/ready handshake on both sides, flush support, and a saturation event counter.
- Sits in the execute stage beside the ALU as its own functional unit; issue provides operands and transaction ID, writeback consumes the result.

---
 rtl/polar_simd_unit_pkg.sv | 13 +
 rtl/polar_simd_unit_lane.sv | 62 ++++++
 rtl/polar_simd_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/polar_simd_unit_pkg.sv
// Shared types and defaults for the packed polar-decoding SIMD unit.
package polar_simd_unit_pkg;

  localparam int unsigned QTF_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    PL_NOP = 2'd0,
    PL_F   = 2'd1,
    PL_G   = 2'd2,
    PL_R   = 2'd3
  } polar_op_t;

endpackage

// File: rtl/polar_simd_unit_lane.sv
// Single-lane combinational datapath for the polar F / G / R operations.
// All arithmetic is done one bit wider than the lane so nothing wraps, and
// results are clamped to the symmetric range [-MAXV, MAXV].
module polar_lane
  import polar_simd_unit_pkg::*;
#(
  parameter int unsigned QTF_SIZE = QTF_SIZE_DEFAULT
) (
  input  polar_op_t             op_i,
  input  logic [QTF_SIZE-1:0]   a_i,
  input  logic [QTF_SIZE-1:0]   b_i,
  input  logic                  beta_i,
  output logic [QTF_SIZE-1:0]   result_o,
  output logic                  sat_o
);

  localparam logic signed [QTF_SIZE:0] MAXV     = {2'b00, {(QTF_SIZE-1){1'b1}}};
  localparam logic signed [QTF_SIZE:0] NEG_MAXV = -MAXV;
  localparam logic [QTF_SIZE-1:0]      MIN_CODE = {1'b1, {(QTF_SIZE-1){1'b0}}};

  logic signed [QTF_SIZE:0] a_x, b_x, abs_a, abs_b, mag, neg_mag, raw;

  // Widen operands, form clamped magnitudes and the G sum/difference.
  always_comb begin
    a_x     = $signed({a_i[QTF_SIZE-1], a_i});
    b_x     = $signed({b_i[QTF_SIZE-1], b_i});
    abs_a   = a_x[QTF_SIZE] ? -a_x : a_x;
    abs_b   = b_x[QTF_SIZE] ? -b_x : b_x;
    if (abs_a > MAXV) abs_a = MAXV;
    if (abs_b > MAXV) abs_b = MAXV;
    mag     = (abs_a < abs_b) ? abs_a : abs_b;
    neg_mag = -mag;
    raw     = beta_i ? (b_x - a_x) : (b_x + a_x);
  end

  // Select the per-op result and the lane saturation flag.
  always_comb begin
    result_o = '0;
    sat_o    = 1'b0;
    case (op_i)
      PL_F: begin
        result_o = (a_i[QTF_SIZE-1] ^ b_i[QTF_SIZE-1]) ? neg_mag[QTF_SIZE-1:0]
                                                       : mag[QTF_SIZE-1:0];
        sat_o    = (a_i == MIN_CODE) || (b_i == MIN_CODE);
      end
      PL_G: begin
        if (raw > MAXV) begin
          result_o = MAXV[QTF_SIZE-1:0];
          sat_o    = 1'b1;
        end else if (raw < NEG_MAXV) begin
          result_o = NEG_MAXV[QTF_SIZE-1:0];
          sat_o    = 1'b1;
        end else begin
          result_o = raw[QTF_SIZE-1:0];
        end
      end
      PL_R:    result_o = {{(QTF_SIZE-1){1'b0}}, ~beta_i & a_i[QTF_SIZE-1]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/polar_simd_unit.sv
// Two-stage pipelined SIMD unit for packed polar-decoding LLR ops.
// Handshake: a transfer happens on a rising edge where valid && ready, on
// both the issue side (op_valid_i/op_ready_o) and the writeback side
// (result_valid_o/result_ready_i). op_ready_o depends only on pipeline
// occupancy and result_ready_i, never on op_valid_i. While result_valid_o is
// high and result_ready_i low, the result, tag and sat outputs hold.
module polar_simd_unit
  import polar_simd_unit_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned QTF_SIZE      = QTF_SIZE_DEFAULT,
  parameter int unsigned LANES         = XLEN / QTF_SIZE,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  polar_op_t                op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [LANES-1:0]         beta_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     sat_o,
  output logic [CNT_WIDTH-1:0]     sat_count_o
);

  localparam int unsigned LW = LANES * QTF_SIZE;

  logic [LW-1:0]    lane_res;
  logic [LANES-1:0] lane_sat;

  logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [LW-1:0]            s1_res_q, s1_res_d, s2_res_q, s2_res_d;
  logic                     s1_sat_q, s1_sat_d, s2_sat_q, s2_sat_d;
  logic [TRANS_ID_BITS-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     s2_adv, accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    polar_lane #(.QTF_SIZE(QTF_SIZE)) u_lane (
      .op_i     (op_i),
      .a_i      (operand_a_i[g*QTF_SIZE +: QTF_SIZE]),
      .b_i      (operand_b_i[g*QTF_SIZE +: QTF_SIZE]),
      .beta_i   (beta_i[g]),
      .result_o (lane_res[g*QTF_SIZE +: QTF_SIZE]),
      .sat_o    (lane_sat[g])
    );
  end

  // Handshake: S2 drains when empty or taken; S1 may refill whenever S2 moves.
  always_comb begin
    s2_adv     = !s2_valid_q || result_ready_i;
    op_ready_o = !s1_valid_q || s2_adv;
    accept     = op_valid_i && op_ready_o;
  end

  // Stage 1 next state: capture lane results on accept; flush drops everything.
  always_comb begin
    s1_res_d   = s1_res_q;
    s1_sat_d   = s1_sat_q;
    s1_tag_d   = s1_tag_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_res_d = lane_res;
      s1_sat_d = |lane_sat;
      s1_tag_d = trans_id_i;
    end
    if (flush_i)     s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (s2_adv) s1_valid_d = 1'b0;
  end

  // Stage 2 next state: shift S1 forward only when S2 advances, else hold.
  always_comb begin
    s2_res_d   = s2_res_q;
    s2_sat_d   = s2_sat_q;
    s2_tag_d   = s2_tag_q;
    s2_valid_d = s2_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_res_d = s1_res_q;
      s2_sat_d = s1_sat_q;
      s2_tag_d = s1_tag_q;
    end
    if (flush_i)     s2_valid_d = 1'b0;
    else if (s2_adv) s2_valid_d = s1_valid_q;
  end

  // Saturating count of saturated results handed to writeback (flush-immune).
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && result_ready_i && s2_sat_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_sat_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_sat_q   <= 1'b0;
      s2_tag_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_res_q   <= s1_res_d;
      s1_sat_q   <= s1_sat_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_sat_q   <= s2_sat_d;
      s2_tag_q   <= s2_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output mapping; bits above the packed lanes read as zero.
  always_comb begin
    result_o         = '0;
    result_o[LW-1:0] = s2_res_q;
    result_valid_o   = s2_valid_q;
    trans_id_o       = s2_tag_q;
    sat_o            = s2_sat_q;
    sat_count_o      = cnt_q;
  end

endmodule
